// File: rtl/pico_riscv_core_p.sv
// Tiny 16-bit-instruction RISC core: byte-serial imem loader, 8 x DATA_W regs, ALU/store/branch/halt.
// Define PICO_SIGNED_CMP_EN for two's-complement SLT/SLTI/BLT/BGE (default build compares unsigned).
module pico_riscv_core_p #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ld_valid,
  input  logic [7:0]                    ld_byte,
  input  logic                          run,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          busy,
  output logic                          halted
);
  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int SH_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  // rs2 shares bits [10:8] with the low bits of imm5
  typedef struct packed {
    logic [2:0] funct3;
    logic [4:0] imm5;
    logic [2:0] rs1;
    logic [2:0] rd;
    logic [1:0] op;
  } insn_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [7:0]        lo_q, lo_d;
  logic [PC_W-1:0]   wptr_q, wptr_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic [15:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs_q [8];

  logic [15:0]       word;
  insn_t             ins;
  logic [2:0]        rs2_idx;
  logic [DATA_W-1:0] rs1v, rs2v, imm_z, alu_r, alu_i, rf_wd;
  logic [SH_W-1:0]   shamt;
  logic              lt_rr, lt_ri, taken, imem_we, rf_we;
  logic [7:0]        br_off;
  logic [PC_W-1:0]   pc_tgt;

  assign word    = imem[pc_q];
  assign ins     = insn_t'(word);
  assign rs2_idx = ins.imm5[2:0];
  assign rs1v    = (ins.rs1 == 3'd0) ? '0 : regs_q[ins.rs1];
  assign rs2v    = (rs2_idx == 3'd0) ? '0 : regs_q[rs2_idx];
  assign shamt   = rs2v[SH_W-1:0];
  assign imm_z   = {{(DATA_W-5){1'b0}}, ins.imm5};
  assign br_off  = {{3{ins.imm5[4]}}, ins.imm5};
  assign pc_tgt  = pc_q + br_off[PC_W-1:0];

`ifdef PICO_SIGNED_CMP_EN
  logic [DATA_W-1:0] imm_s;
  assign imm_s = {{(DATA_W-5){ins.imm5[4]}}, ins.imm5};
  assign lt_rr = $signed(rs1v) < $signed(rs2v);
  assign lt_ri = $signed(rs1v) < $signed(imm_s);
`else
  assign lt_rr = rs1v < rs2v;
  assign lt_ri = rs1v < imm_z;
`endif

  always_comb begin
    alu_r = '0;
    unique case (ins.funct3)
      3'b000: alu_r = rs1v + rs2v;
      3'b001: alu_r = rs1v - rs2v;
      3'b010: alu_r = rs1v & rs2v;
      3'b011: alu_r = rs1v | rs2v;
      3'b100: alu_r = rs1v ^ rs2v;
      3'b101: alu_r = rs1v << shamt;
      3'b110: alu_r = rs1v >> shamt;
      3'b111: alu_r = {{(DATA_W-1){1'b0}}, lt_rr};
    endcase
  end

  always_comb begin
    alu_i = imm_z;
    unique case (ins.funct3)
      3'b000:  alu_i = rs1v + imm_z;
      3'b010:  alu_i = {{(DATA_W-1){1'b0}}, lt_ri};
      3'b011:  alu_i = rs1v & imm_z;
      3'b100:  alu_i = rs1v | imm_z;
      default: alu_i = imm_z;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    unique case (ins.funct3[1:0])
      2'b00: taken = (rs1v == rs2v);
      2'b01: taken = (rs1v != rs2v);
      2'b10: taken = lt_rr;
      2'b11: taken = !lt_rr;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    lo_d        = lo_q;
    wptr_d      = wptr_q;
    pc_d        = pc_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    imem_we     = 1'b0;
    rf_we       = 1'b0;
    rf_wd       = ins.op[0] ? alu_i : alu_r;
    unique case (state_q)
      S_IDLE: begin
        // a pending load byte wins over run, and run waits for a word boundary
        if (ld_valid) begin
          if (!phase_q) begin
            lo_d    = ld_byte;
            phase_d = 1'b1;
          end else begin
            imem_we = 1'b1;
            wptr_d  = wptr_q + PC_W'(1);
            phase_d = 1'b0;
          end
        end else if (run && !phase_q) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!run) begin
          state_d = S_IDLE;
        end else if (word == 16'hFFFF) begin
          state_d = S_HALT;
        end else begin
          pc_d = pc_q + PC_W'(1);
          unique case (ins.op)
            2'b00, 2'b01: rf_we = 1'b1;
            2'b10: begin
              out_data_d  = rs2v;
              out_valid_d = 1'b1;
            end
            2'b11: if (taken) pc_d = pc_tgt;
          endcase
        end
      end
      S_HALT: begin
        if (!run) begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      phase_q     <= 1'b0;
      lo_q        <= '0;
      wptr_q      <= '0;
      pc_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      lo_q        <= lo_d;
      wptr_q      <= wptr_d;
      pc_q        <= pc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (rf_we && ins.rd != 3'd0) begin
      regs_q[ins.rd] <= rf_wd;
    end
  end

  // program memory survives reset so a loaded image can be rerun
  always_ff @(posedge clk) begin
    if (imem_we) imem[wptr_q] <= {ld_byte, lo_q};
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign pc        = pc_q;
  assign busy      = (state_q == S_RUN);
  assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_pico_riscv_core_p.sv
// Bench for pico_riscv_core_p: loads small programs, scoreboards stores, checks pc/state flags.
module tb_pico_riscv_core_p;
  logic       clk = 1'b0, rst_n = 1'b1, ld_valid = 1'b0, run = 1'b0;
  logic [7:0] ld_byte = 8'h00;
  logic [7:0] out_data;
  logic       out_valid, busy, halted;
  logic [3:0] pc;

  int          checks = 0, errors = 0;
  logic [7:0]  sbq[$];
  logic [7:0]  exp_v;
  bit          sb_on = 1'b1;
  logic [15:0] prog[16];

  always #5 clk = ~clk;

  pico_riscv_core_p #(.DATA_W(8), .IMEM_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_byte(ld_byte), .run(run),
    .out_data(out_data), .out_valid(out_valid), .pc(pc), .busy(busy), .halted(halted)
  );

  always @(negedge clk) begin
    if (rst_n && sb_on && out_valid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL store_unexpected got %0d expected no store", out_data);
      end else begin
        exp_v = sbq.pop_front();
        if (out_data !== exp_v) begin
          errors++;
          $display("FAIL store_data got %0d expected %0d", out_data, exp_v);
        end
      end
    end
  end

  function automatic logic [15:0] r_op(input logic [2:0] f3, rd, rs1, rs2);
    return {f3, 2'b00, rs2, rs1, rd, 2'b00};
  endfunction
  function automatic logic [15:0] i_op(input logic [2:0] f3, rd, rs1, input logic [4:0] imm);
    return {f3, imm, rs1, rd, 2'b01};
  endfunction
  function automatic logic [15:0] st_op(input logic [2:0] rs2);
    return {5'b00000, rs2, 3'b000, 3'b000, 2'b10};
  endfunction
  function automatic logic [15:0] br_op(input logic [1:0] f2, input logic [2:0] rs1, input logic [4:0] imm);
    return {1'b0, f2, imm, rs1, 3'b000, 2'b11};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    run = 1'b0; ld_valid = 1'b0;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sbq.delete();
    sb_on = 1'b1;
    step();
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1; ld_byte = prog[i][7:0];  step();
      ld_byte = prog[i][15:8]; step();
    end
    ld_valid = 1'b0;
  endtask

  task automatic run_to_halt(output bit ok);
    int n = 0;
    while (halted !== 1'b1 && n < 300) begin step(); n++; end
    ok = (halted === 1'b1);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #2;
    checks++;
    if ({pc, busy, halted, out_valid, out_data} !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got pc=%0d busy=%b halted=%b ov=%b od=%0d expected all 0",
               pc, busy, halted, out_valid, out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    prog[0] = 16'h0505; prog[1] = 16'h0102; prog[2] = 16'hFFFF;
    load(3);
    sbq.push_back(8'd5);
    run = 1'b1;
    run_to_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_halt got halted=%b expected 1", halted); end
    checks++; if (pc !== 4'd2) begin errors++; $display("FAIL basic_pc got %0d expected 2", pc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b expected 0", busy); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL basic_stores got %0d left expected 0", sbq.size()); end
  endtask

  task automatic test_alu();
    bit ok;
    do_reset();
    prog[0]  = i_op(3'd0, 3'd1, 3'd0, 5'd31);
    prog[1]  = r_op(3'd0, 3'd2, 3'd1, 3'd1);
    prog[2]  = st_op(3'd2);
    prog[3]  = i_op(3'd0, 3'd4, 3'd0, 5'd1);
    prog[4]  = r_op(3'd1, 3'd1, 3'd0, 3'd4);
    prog[5]  = r_op(3'd0, 3'd2, 3'd1, 3'd1);
    prog[6]  = st_op(3'd2);
    prog[7]  = i_op(3'd0, 3'd3, 3'd0, 5'd3);
    prog[8]  = r_op(3'd5, 3'd5, 3'd1, 3'd3);
    prog[9]  = r_op(3'd4, 3'd6, 3'd5, 3'd1);
    prog[10] = st_op(3'd6);
    prog[11] = r_op(3'd6, 3'd6, 3'd1, 3'd3);
    prog[12] = r_op(3'd2, 3'd6, 3'd6, 3'd5);
    prog[13] = st_op(3'd6);
    prog[14] = st_op(3'd5);
    prog[15] = 16'hFFFF;
    load(16);
    sbq.push_back(8'd62); sbq.push_back(8'd254); sbq.push_back(8'd7);
    sbq.push_back(8'd24); sbq.push_back(8'd248);
    run = 1'b1;
    run_to_halt(ok);
    checks++; if (!ok) begin errors++; $display("FAIL alu_halt got halted=%b expected 1", halted); end
    checks++; if (pc !== 4'd15) begin errors++; $display("FAIL alu_pc got %0d expected 15", pc); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL alu_stores got %0d left expected 0", sbq.size()); end
  endtask

  task automatic test_imm_slt();
    bit ok;
    logic [7:0] slt_exp;
`ifdef PICO_SIGNED_CMP_EN
    slt_exp = 8'd1;
`else
    slt_exp = 8'd0;
`endif
    do_reset();
    prog[0]  = i_op(3'd0, 3'd0, 3'd0, 5'd5);
    prog[1]  = st_op(3'd0);
    prog[2]  = i_op(3'd7, 3'd1, 3'd0, 5'd20);
    prog[3]  = i_op(3'd3, 3'd2, 3'd1, 5'd6);
    prog[4]  = i_op(3'd4, 3'd2, 3'd2, 5'd9);
    prog[5]  = st_op(3'd2);
    prog[6]  = i_op(3'd2, 3'd3, 3'd2, 5'd14);
    prog[7]  = st_op(3'd3);
    prog[8]  = i_op(3'd0, 3'd4, 3'd0, 5'd1);
    prog[9]  = i_op(3'd0, 3'd6, 3'd0, 5'd7);
    prog[10] = r_op(3'd5, 3'd5, 3'd4, 3'd6);
    prog[11] = r_op(3'd7, 3'd6, 3'd5, 3'd4);
    prog[12] = st_op(3'd6);
    prog[13] = st_op(3'd5);
    prog[14] = 16'hFFFF;
    load(15);
    sbq.push_back(8'd0); sbq.push_back(8'd13); sbq.push_back(8'd1);
    sbq.push_back(slt_exp); sbq.push_back(8'd128);
    run = 1'b1;
    run_to_halt(ok);
    checks++; if (!ok || pc !== 4'd14) begin errors++; $display("FAIL imm_halt got halted=%b pc=%0d expected 1/14", halted, pc); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL imm_stores got %0d left expected 0", sbq.size()); end
  endtask

  task automatic test_branch();
    bit ok;
    do_reset();
    for (int i = 0; i < 16; i++) prog[i] = 16'hFFFF;
    prog[0]  = br_op(2'b00, 3'd0, 5'b11111);
    prog[1]  = i_op(3'd0, 3'd1, 3'd0, 5'd3);
    prog[2]  = br_op(2'b01, 3'd1, 5'b01000);
    prog[3]  = br_op(2'b11, 3'd0, 5'b01001);
    prog[4]  = st_op(3'd1);
    prog[10] = br_op(2'b10, 3'd0, 5'b11001);
    prog[15] = br_op(2'b00, 3'd0, 5'b00010);
    load(16);
    sbq.push_back(8'd3);
    run = 1'b1;
    step(); step();
    checks++; if (pc !== 4'd15) begin errors++; $display("FAIL branch_back got pc=%0d expected 15", pc); end
    run_to_halt(ok);
    checks++; if (!ok || pc !== 4'd5) begin errors++; $display("FAIL branch_end got halted=%b pc=%0d expected 1/5", halted, pc); end
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL branch_stores got %0d left expected 0", sbq.size()); end
  endtask

  task automatic test_pause_resume();
    bit ok;
    do_reset();
    prog[0] = i_op(3'd0, 3'd1, 3'd1, 5'd1);
    prog[1] = st_op(3'd1);
    prog[2] = 16'hFFFF;
    load(3);
    run = 1'b1;
    step(); step();
    run = 1'b0;
    step();
    checks++; if (busy !== 1'b0 || pc !== 4'd1) begin errors++; $display("FAIL pause got busy=%b pc=%0d expected 0/1", busy, pc); end
    sbq.push_back(8'd1);
    run = 1'b1;
    run_to_halt(ok);
    checks++; if (!ok || pc !== 4'd2) begin errors++; $display("FAIL resume got halted=%b pc=%0d expected 1/2", halted, pc); end
    run = 1'b0;
    step();
    checks++; if (halted !== 1'b0 || pc !== 4'd0) begin errors++; $display("FAIL halt_exit got halted=%b pc=%0d expected 0/0", halted, pc); end
    sbq.push_back(8'd2);
    run = 1'b1;
    run_to_halt(ok);
    checks++; if (!ok || sbq.size() != 0) begin errors++; $display("FAIL rerun got halted=%b left=%0d expected 1/0", halted, sbq.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    prog[0] = i_op(3'd0, 3'd1, 3'd1, 5'd1);
    prog[1] = st_op(3'd1);
    prog[2] = br_op(2'b00, 3'd0, 5'b11110);
    load(3);
    sb_on = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checks++; if (busy !== 1'b1 || out_data === 8'd0) begin errors++; $display("FAIL loop_running got busy=%b od=%0d expected 1/nonzero", busy, out_data); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pc, busy, halted, out_valid, out_data} !== 16'h0) begin
      errors++;
      $display("FAIL reset_run got pc=%0d busy=%b halted=%b ov=%b od=%0d expected all 0", pc, busy, halted, out_valid, out_data);
    end
    run = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sb_on = 1'b1;
    step();
    ld_valid = 1'b1; ld_byte = 8'hAA; step(); ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({pc, busy, halted, out_valid, out_data} !== 16'h0) begin errors++; $display("FAIL reset_load got nonzero outputs expected all 0"); end
    @(negedge clk) rst_n = 1'b1;
    step();
    prog[0] = 16'h0505; prog[1] = 16'h0102; prog[2] = 16'hFFFF;
    load(3);
    sbq.push_back(8'd5);
    run = 1'b1;
    run_to_halt(ok);
    checks++; if (!ok || pc !== 4'd2 || sbq.size() != 0) begin errors++; $display("FAIL reload got halted=%b pc=%0d left=%0d expected 1/2/0", halted, pc, sbq.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] b[6] = '{8'h05, 8'h05, 8'h02, 8'h01, 8'hFF, 8'hFF};
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_byte = b[i]; step();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld_priority byte %0d got busy=%b expected 0", i, busy); end
    end
    ld_valid = 1'b0;
    sbq.push_back(8'd5);
    step();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld_then_run got busy=%b expected 1", busy); end
    run_to_halt(ok);
    checks++; if (!ok || pc !== 4'd2 || sbq.size() != 0) begin errors++; $display("FAIL ld_run_end got halted=%b pc=%0d left=%0d expected 1/2/0", halted, pc, sbq.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_alu();
    test_imm_slt();
    test_branch();
    test_pause_resume();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pico_riscv_core_p.md
PICO_RISCV_CORE_P -- requirements
Module: pico_riscv_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8: register and ALU width, legal range 8..32.
REQ-002 SHALL have parameter IMEM_DEPTH, default 16: instruction memory depth in 16-bit words, power of two in 4..256; PC_W = log2(IMEM_DEPTH).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port ld_valid, input, 1 bit: qualifies ld_byte for instruction loading.
REQ-006 SHALL have port ld_byte, input, 8 bits: instruction byte, low byte first.
REQ-007 SHALL have port run, input, 1 bit: level; 1 requests execution from instruction memory.
REQ-008 SHALL have port out_data, output, DATA_W bits: value of the most recent store.
REQ-009 SHALL have port out_valid, output, 1 bit: one-cycle pulse per executed store.
REQ-010 SHALL have port pc, output, PC_W bits: current program counter.
REQ-011 SHALL have port busy, output, 1 bit: high in RUN.
REQ-012 SHALL have port halted, output, 1 bit: high in HALT.

Function
REQ-013 SHALL implement states IDLE, RUN and HALT, plus a 1-bit byte-phase flag and a PC_W-bit write pointer used in IDLE.
REQ-014 SHALL, in IDLE, latch ld_byte on each ld_valid cycle: phase 0 latches the low byte; phase 1 writes {ld_byte, low} to imem[wptr], increments wptr modulo IMEM_DEPTH and returns phase to 0.
REQ-015 SHALL ignore ld_valid in RUN and HALT.
REQ-016 SHALL go IDLE->RUN when run=1, ld_valid=0 and phase=0; if run and ld_valid are both high in IDLE, the load takes priority and the state stays IDLE.
REQ-017 SHALL, in RUN, execute one instruction per cycle from imem[pc]; fields: opcode[1:0], rd[4:2], rs1[7:5], rs2[10:8], imm5[12:8], funct3[15:13].
REQ-018 SHALL provide 8 registers of DATA_W bits; x0 always reads 0, and writes to x0 are discarded.
REQ-019 SHALL execute opcode 00 (R-type) by funct3: ADD, SUB, AND, OR, XOR, SLL, SRL, SLT; shift amount = rs2[log2(DATA_W)-1:0]; results are truncated to DATA_W.
REQ-020 SHALL execute opcode 01 (I-type) with imm5 zero-extended: funct3 000 ADDI, 010 SLTI, 011 ANDI, 100 ORI; any other funct3 is LI (rd=imm).
REQ-021 SHALL execute opcode 10 (store) by setting out_data<=x[rs2] and out_valid=1 for exactly that cycle.
REQ-022 SHALL execute opcode 11 (branch) with the condition from the current-cycle operands: funct3[1:0] 00 BEQ, 01 BNE, 10 BLT, 11 BGE.
REQ-023 SHALL, on a taken branch, set pc <= pc + sign-extended imm5 (-16..+15) modulo IMEM_DEPTH; on a not-taken branch, pc <= pc+1.
REQ-024 SHALL, for every non-branch instruction, set pc <= pc+1 modulo IMEM_DEPTH; the increment wraps silently from IMEM_DEPTH-1 to 0.
REQ-025 SHALL treat word 16'hFFFF as HALT: no register write, pc unchanged, state -> HALT.
REQ-026 SHALL, in RUN with run=0, go to IDLE with pc and registers held; a later run=1 resumes from pc.
REQ-027 SHALL, in HALT with run=0, go to IDLE and set pc=0; registers and the write pointer are held.
REQ-028 SHALL perform a load-pointer restart only on reset; the write pointer wraps modulo IMEM_DEPTH.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-load or mid-run, immediately set state=IDLE, phase=0, wptr=0, pc=0, all registers=0, out_data=0, out_valid=0, busy=0 and halted=0.
REQ-030 SHALL leave imem contents unaffected by reset.
REQ-031 SHALL leave reset synchronously to clk at the first rising edge after rst_n rises.

Configuration
REQ-032 SHALL, when macro PICO_SIGNED_CMP_EN is defined, treat SLT, SLTI (imm5 sign-extended), BLT and BGE as two's-complement signed.
REQ-033 SHALL, when PICO_SIGNED_CMP_EN is undefined, treat all comparisons as unsigned and zero-extend the SLTI immediate.

Verification
REQ-034 SHALL cover: load bytes 05,05,02,01,FF,FF, then run=1 -> out_valid pulses once with out_data=5, then halted=1 with pc=2.
REQ-035 SHALL cover: ADDI x1,x0,31 then ADD x2,x1,x1 with DATA_W=8 -> x2=62; with x1=255, ADD gives 254 (wrap).
REQ-036 SHALL cover: BEQ x0,x0 with imm5=-1 at pc=0, IMEM_DEPTH=16 -> pc=15 on the next cycle.
REQ-037 SHALL cover: x1=0x80, x2=1, SLT x3,x1,x2 -> x3=0 without PICO_SIGNED_CMP_EN and x3=1 with it.
REQ-038 SHALL cover: rst_n low during RUN or after one load byte -> all outputs 0 on the same cycle; a reload from wptr=0 with phase=0 then succeeds.
REQ-039 SHALL cover: run and ld_valid high together in IDLE -> the byte is stored, busy stays 0, and RUN is entered on the next cycle with ld_valid=0.
